// File: rtl/arm_pkg.sv
// Shared types and widths for the instruction fetch path.
package arm_pkg;

    localparam int WORD_BYTES = 4;
    localparam int INSTR_W    = 32;
    localparam int ADDR_W     = 32;
    localparam int ENTRY_W    = ADDR_W + INSTR_W;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction memory req/ack bus plus the valid/ready channel into IF/ID.
interface fetch_controller_if;
    import arm_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_valid;
    logic [ADDR_W-1:0]  if_pc;
    logic [INSTR_W-1:0] if_instruction;
    logic               if_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instruction,
        input  imem_ack, imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instruction,
        output imem_ack, imem_rdata, if_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Small circular prefetch buffer of {pc+4, instruction}; flush beats push/pop.
module fetch_queue
    import arm_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] head_data,
    output logic [CW-1:0]      count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]      rd_q, wr_q;
    logic [CW-1:0]      count_q;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            rd_q    <= wr_q;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    assign head_data = mem_q[rd_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer: owns the PC, runs the imem req/ack handshake and
// fills the prefetch queue; a redirect flushes the queue and drops any in-flight word.
module fetch_controller
    import arm_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    fetch_controller_if.master fc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  fetch_pc_q;
    logic [ADDR_W-1:0]  imem_addr_q;
    logic               imem_req_q;

    logic [CW-1:0]      count;
    logic [ENTRY_W-1:0] head_data;
    logic               push, pop, flush, room;
    logic [CW:0]        cnt_after;
    logic [ADDR_W-1:0]  pc_inc, br_tgt;

    assign pc_inc = fetch_pc_q + ADDR_W'(WORD_BYTES);
    assign br_tgt = word_align(branch_addr);

    assign pop   = (count != '0) && fc.if_ready && !branch_taken;
    assign push  = (state_q == FS_WAIT) && fc.imem_ack && !branch_taken;
    assign flush = branch_taken;

    // Occupancy after this edge decides whether the next request may go out back-to-back.
    assign cnt_after = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    assign room      = cnt_after < DEPTH_X;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FS_IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_addr_q <= RESET_PC;
            imem_req_q  <= 1'b0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (branch_taken) begin
                        fetch_pc_q <= br_tgt;
                    end else if (count < DEPTH_C) begin
                        imem_addr_q <= fetch_pc_q;
                        imem_req_q  <= 1'b1;
                        state_q     <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (fc.imem_ack) begin
                        if (branch_taken) begin
                            fetch_pc_q <= br_tgt;
                            imem_req_q <= 1'b0;
                            state_q    <= FS_IDLE;
                        end else begin
                            fetch_pc_q <= pc_inc;
                            if (room) begin
                                imem_addr_q <= pc_inc;
                            end else begin
                                imem_req_q <= 1'b0;
                                state_q    <= FS_IDLE;
                            end
                        end
                    end else if (branch_taken) begin
                        // Request cannot be withdrawn; wait out its ack and drop the word.
                        fetch_pc_q <= br_tgt;
                        state_q    <= FS_DROP;
                    end
                end
                FS_DROP: begin
                    if (branch_taken) fetch_pc_q <= br_tgt;
                    if (fc.imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= FS_IDLE;
                    end
                end
                default: begin
                    imem_req_q <= 1'b0;
                    state_q    <= FS_IDLE;
                end
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({pc_inc, fc.imem_rdata}),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_data),
        .count     (count)
    );

    assign fc.imem_req       = imem_req_q;
    assign fc.imem_addr      = imem_addr_q;
    assign fc.if_valid       = (count != '0);
    assign fc.if_pc          = head_data[ENTRY_W-1:INSTR_W];
    assign fc.if_instruction = head_data[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: streaming, wait states, back-pressure,
// redirects, PC wrap and asynchronous reset.
module tb_fetch_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        ack = 1'b0;
    logic        ready = 1'b0;
    int          errors = 0;
    int          checks = 0;

    fetch_controller_if fc ();

    assign fc.imem_ack   = ack;
    assign fc.if_ready   = ready;
    assign fc.imem_rdata = fc.imem_addr >> 2;

    fetch_controller #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .fc           (fc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic a, input logic r);
        rst = 1'b0;
        branch_taken = 1'b0;
        branch_addr = '0;
        ack = a;
        ready = r;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // A push into a full queue must never happen.
    always @(negedge clk)
        if (rst && dut.push) chk("push_when_full", 32'(dut.count == 2'd2), 32'd0);

    initial begin
        // reset state and streaming with ack tied high
        #1 rst = 1'b0;
        #1;
        chk("rst req", 32'(fc.imem_req), 0);
        chk("rst addr", fc.imem_addr, 32'h0);
        chk("rst valid", 32'(fc.if_valid), 0);
        chk("rst pc", fc.if_pc, 0);
        chk("rst instr", fc.if_instruction, 0);
        do_reset(1'b1, 1'b1);
        step();
        chk("t1 req", 32'(fc.imem_req), 1);
        chk("t1 addr0", fc.imem_addr, 0);
        chk("t1 valid0", 32'(fc.if_valid), 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t1 addr", fc.imem_addr, 32'(4 * k));
            chk("t1 valid", 32'(fc.if_valid), 1);
            chk("t1 pc", fc.if_pc, 32'(4 * k));
            chk("t1 instr", fc.if_instruction, 32'(k - 1));
        end

        // three wait states per request
        do_reset(1'b0, 1'b1);
        step();
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 4; w++) begin
                chk("t2 req", 32'(fc.imem_req), 1);
                chk("t2 addr", fc.imem_addr, 32'(4 * r));
                if (r > 0 && w == 0) begin
                    chk("t2 valid", 32'(fc.if_valid), 1);
                    chk("t2 pc", fc.if_pc, 32'(4 * r));
                    chk("t2 instr", fc.if_instruction, 32'(r - 1));
                end
                if (r > 0 && w == 1) chk("t2 single push", 32'(fc.if_valid), 0);
                ack = (w == 3);
                step();
            end
        end
        ack = 1'b0;

        // back-pressure from reset: queue fills then fetch stalls
        do_reset(1'b1, 1'b0);
        repeat (3) step();
        chk("t3 req stall", 32'(fc.imem_req), 0);
        chk("t3 pc head", fc.if_pc, 32'd4);
        step();
        chk("t3 req held", 32'(fc.imem_req), 0);
        chk("t3 pc held", fc.if_pc, 32'd4);
        ready = 1'b1;
        step();
        chk("t3 pc2", fc.if_pc, 32'd8);
        chk("t3 instr2", fc.if_instruction, 32'd1);
        step();
        chk("t3 resume req", 32'(fc.imem_req), 1);
        chk("t3 resume addr", fc.imem_addr, 32'd8);
        chk("t3 empty", 32'(fc.if_valid), 0);
        step();
        chk("t3 pc3", fc.if_pc, 32'd12);
        chk("t3 instr3", fc.if_instruction, 32'd2);

        // redirect while waiting: in-flight word dropped
        do_reset(1'b0, 1'b1);
        step();
        branch_taken = 1'b1;
        branch_addr = 32'h40;
        step();
        branch_taken = 1'b0;
        chk("t4 drop req", 32'(fc.imem_req), 1);
        chk("t4 drop addr", fc.imem_addr, 32'h0);
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t4 idle req", 32'(fc.imem_req), 0);
        chk("t4 discarded", 32'(fc.if_valid), 0);
        step();
        chk("t4 new addr", fc.imem_addr, 32'h40);
        chk("t4 new req", 32'(fc.imem_req), 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t4 valid", 32'(fc.if_valid), 1);
        chk("t4 pc", fc.if_pc, 32'h44);
        chk("t4 instr", fc.if_instruction, 32'h10);

        // redirect coinciding with ack and pop, unaligned target
        do_reset(1'b1, 1'b0);
        step();
        step();
        chk("t5 one entry", 32'(fc.if_valid), 1);
        ready = 1'b1;
        branch_taken = 1'b1;
        branch_addr = 32'h103;
        step();
        branch_taken = 1'b0;
        ack = 1'b0;
        chk("t5 flushed", 32'(fc.if_valid), 0);
        chk("t5 req", 32'(fc.imem_req), 0);
        step();
        chk("t5 new addr", fc.imem_addr, 32'h100);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t5 pc", fc.if_pc, 32'h104);
        chk("t5 instr", fc.if_instruction, 32'h40);

        // redirect in IDLE to last word: PC wraps
        do_reset(1'b0, 1'b1);
        branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk("t6 idle req", 32'(fc.imem_req), 0);
        ack = 1'b1;
        step();
        chk("t6 top addr", fc.imem_addr, 32'hFFFF_FFFC);
        step();
        ack = 1'b0;
        chk("t6 wrap addr", fc.imem_addr, 32'h0);
        chk("t6 wrap pc", fc.if_pc, 32'h0);
        chk("t6 wrap instr", fc.if_instruction, 32'h3FFF_FFFF);

        // asynchronous reset between edges
        do_reset(1'b1, 1'b0);
        step();
        step();
        chk("t7 pre valid", 32'(fc.if_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("t7 async req", 32'(fc.imem_req), 0);
        chk("t7 async valid", 32'(fc.if_valid), 0);
        chk("t7 async addr", fc.imem_addr, 32'h0);
        step();
        rst = 1'b1;
        ack = 1'b0;
        step();
        chk("t7 post req", 32'(fc.imem_req), 1);
        chk("t7 post addr", fc.imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the instruction memory for the IF stage.
- Owns the fetch PC and issues word requests over a req/ack handshake, so memory latency may vary (0..N wait cycles).
- Buffers returned words with their PC+4 in a small prefetch queue that feeds the IF/ID register through a valid/ready interface.
- Handles branch redirect, including discarding any fetch already in flight.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; word-aligned.
- DEPTH, 2, prefetch queue entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- branch_taken  in  1  redirect request from EXE stage.
- branch_addr  in  32  redirect target; bits [1:0] ignored, treated as 0.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  byte address of the requested word; always word-aligned.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  queue head is valid.
- if_pc  out  32  PC+4 of the head instruction.
- if_instruction  out  32  head instruction word.
- if_ready  in  1  IF/ID accepts the head; low means freeze/hazard.

Behaviour:
- Reset (async assert) sets:
  - state=IDLE, fetch_pc=RESET_PC, queue count=0;
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instruction=0.
  - Applies immediately, including mid-request; a pending ack is simply ignored.
- Definitions used below:
  - Pop: if_valid && if_ready && !branch_taken. The head leaves the queue at the clock edge.
  - Room after this cycle: count + push - pop < DEPTH.
- FSM states: IDLE, WAIT, DROP. imem_req=1 exactly when state is WAIT or DROP (registered). imem_addr is registered at issue.
- Handshake rule: once imem_req rises, req and addr are held stable until the ack cycle. A request is never withdrawn.
- IDLE:
  - If !branch_taken and count<DEPTH: imem_addr<=fetch_pc, go WAIT.
  - If branch_taken: fetch_pc<=branch_addr, flush queue, stay IDLE. The new request issues the following cycle.
- WAIT, no ack:
  - If branch_taken: fetch_pc<=branch_addr, flush, go DROP.
  - Otherwise hold.
- WAIT with ack and !branch_taken:
  - Push {fetch_pc+4, imem_rdata}; fetch_pc<=fetch_pc+4.
  - If room remains after the push/pop: imem_addr<=fetch_pc+4, stay WAIT (back-to-back). With ack tied high this gives one instruction per cycle.
  - Otherwise go IDLE.
- WAIT with ack and branch_taken: data discarded, no push, fetch_pc<=branch_addr, flush, go IDLE.
- DROP:
  - Ack: discard data, go IDLE.
  - branch_taken in DROP: fetch_pc<=branch_addr, flush, stay DROP until ack.
  - branch_taken together with ack: update fetch_pc, go IDLE.
- Queue:
  - Circular buffer with rd/wr pointers of width log2(DEPTH) that wrap naturally.
  - count has width log2(DEPTH)+1.
  - Simultaneous push and pop is legal at any count, including full, leaving count unchanged.
  - Push when full cannot occur (issue gating guarantees this). A push-when-full check is flagged in the bench.
  - Flush sets count=0 and rd=wr at the edge, so if_valid=0 on the next cycle. Flush wins over a same-cycle push or pop.
- Output timing:
  - if_valid=(count!=0); if_pc and if_instruction are read combinationally from the head entry.
  - Latency is 1 cycle from ack to if_valid.
- Arithmetic:
  - 32-bit unsigned; PC wraps 0xFFFF_FFFC -> 0x0000_0000 silently.
  - if_pc stores PC+4 (the ARM pipeline convention).

Decomposition:
- Shared package (arm_pkg):
  - fetch state encoding (IDLE=2'd0, WAIT=2'd1, DROP=2'd2);
  - WORD_BYTES=4, INSTR_W=32, ADDR_W=32.
- Sub-module fetch_queue:
  - ports: clk, rst, push, push_data[63:0], pop, flush, head_data[63:0], count.
  - fetch_controller instantiates it once.

Test Plan:
- Reset release, ack tied 1, rdata=addr>>2:
  - imem_addr=0,4,8,... on consecutive cycles;
  - if_valid rises 1 cycle after the first ack with if_pc=4, if_instruction=0;
  - one pop per cycle while if_ready=1.
- ack delayed 3 cycles per request: imem_req/imem_addr stable for 4 cycles each; exactly one push per request; if_pc sequence 4,8,12.
- if_ready=0 from reset, ack tied 1:
  - queue fills to 2 (pc 4, 8), then imem_req drops to 0;
  - raising if_ready resumes fetch at addr 8 with no loss or duplication.
- branch_taken=1, branch_addr=0x40 while in WAIT with ack delayed 2 cycles:
  - FSM enters DROP and that returned word is discarded;
  - next imem_addr=0x40; first if_pc after redirect=0x44.
- branch_taken in the same cycle as ack and a pop, queue holding 1 entry: no push; if_valid=0 next cycle; next request addr=branch_addr.
- rst asserted mid-WAIT, asynchronously between edges: imem_req=0 and if_valid=0 immediately; after release, the first imem_addr=RESET_PC.
